// File: rtl/led_switch_io_if.sv
// led_switch_io_if
// CPU-side IO bus between the memory/IO routing logic and the LED/switch
// peripheral.
//   LEDCtrl    : LED chip select, write strobe for the current cycle
//   SwitchCtrl : switch chip select, read strobe for the current cycle
//   addr       : CPU address; the peripheral decodes addr[7:0] only
//   write_data : CPU store data; the peripheral uses bits [15:0] only
//   io_rdata   : combinational read data back to the CPU
// Modports: master = CPU side, slave = peripheral side.

interface led_switch_io_if;
  logic        LEDCtrl;
  logic        SwitchCtrl;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [15:0] io_rdata;

  modport master (
    output LEDCtrl,
    output SwitchCtrl,
    output addr,
    output write_data,
    input  io_rdata
  );

  modport slave (
    input  LEDCtrl,
    input  SwitchCtrl,
    input  addr,
    input  write_data,
    output io_rdata
  );
endinterface

// File: rtl/led_switch_io.sv
// led_switch_io
// Memory-mapped LED/switch peripheral. LED data and a per-bit blink mask are
// written through the LED chip select. Board switches pass through a two-flop
// synchroniser and a whole-vector debounce FSM. A sticky change flag is set on
// every accepted switch change and cleared by reading it.
//
// Ports:
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high
//   bus        : CPU IO bus (slave modport of led_switch_io_if)
//   switch_in  : raw asynchronous board switches
//   led        : board LEDs
//
// Register map (addr[7:0]):
//   0x60 LED data        R/W (write via LEDCtrl)
//   0x64 blink mask      R/W (write via LEDCtrl)
//   0x70 debounced sw    RO
//   0x74 {15'b0, sw_chg} RO, clear-on-read
//
// Debounce FSM:
//   state    | meaning
//   DB_COUNT | candidate vector is counting stable cycles toward acceptance
//   DB_HOLD  | candidate reached the stable-cycle target; count saturated

module led_switch_io #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int BLINK_CYCLES    = 5000000
) (
  input  logic            clock,
  input  logic            reset,
  led_switch_io_if.slave  bus,
  input  logic [15:0]     switch_in,
  output logic [15:0]     led
);

  localparam int CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  localparam logic [7:0] OFF_LED   = 8'h60;
  localparam logic [7:0] OFF_BLINK = 8'h64;
  localparam logic [7:0] OFF_SW    = 8'h70;
  localparam logic [7:0] OFF_CHG   = 8'h74;

  typedef enum logic [0:0] {
    DB_COUNT = 1'b0,
    DB_HOLD  = 1'b1
  } db_state_t;

  logic [7:0]         offset;
  logic [15:0]        wdata;
  logic               unused_bus_bits;

  logic [15:0]        led_reg;
  logic [15:0]        blink_mask;
  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  logic [15:0]        sync1;
  logic [15:0]        sync2;

  db_state_t          state, state_nxt;
  logic [15:0]        cand, cand_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [15:0]        stable, stable_nxt;
  logic               sw_changed, sw_changed_nxt;
  logic               commit;
  logic               clear_chg;

  logic [15:0]        rdata;

  assign offset = bus.addr[7:0];
  assign wdata  = bus.write_data[15:0];

  // Upper address and data bits are not decoded by this peripheral.
  assign unused_bus_bits = ^{bus.addr[31:8], bus.write_data[31:16]};

  // ---------------------------------------------------------------------------
  // LED registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      led_reg    <= '0;
      blink_mask <= '0;
    end else if (bus.LEDCtrl) begin
      case (offset)
        OFF_LED:   led_reg    <= wdata;
        OFF_BLINK: blink_mask <= wdata;
        default:   ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Blink timebase: phase flips once per BLINK_CYCLES clocks.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Masked bits go dark during the odd phase only.
  assign led = led_reg & ~(blink_mask & {16{phase}});

  // ---------------------------------------------------------------------------
  // Switch synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch_in;
      sync2 <= sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= DB_COUNT;
      cand       <= '0;
      cnt        <= '0;
      stable     <= '0;
      sw_changed <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      stable     <= stable_nxt;
      sw_changed <= sw_changed_nxt;
    end
  end

  assign clear_chg = bus.SwitchCtrl && (offset == OFF_CHG);

  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    cnt_nxt    = cnt;
    stable_nxt = stable;
    commit     = 1'b0;

    if (sync2 != cand) begin
      // Any movement of the synchronised vector restarts qualification.
      cand_nxt  = sync2;
      cnt_nxt   = '0;
      state_nxt = DB_COUNT;
    end else begin
      case (state)
        DB_COUNT: begin
          if (cnt == CNT_LAST) begin
            state_nxt = DB_HOLD;
            if (cand != stable) begin
              stable_nxt = cand;
              commit     = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        DB_HOLD: begin
          // Count stays saturated; cand already equals stable here.
        end
      endcase
    end

    // A commit on the same edge as a clearing read keeps the flag set.
    if (commit) begin
      sw_changed_nxt = 1'b1;
    end else if (clear_chg) begin
      sw_changed_nxt = 1'b0;
    end else begin
      sw_changed_nxt = sw_changed;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: SwitchCtrl sees the full map, LEDCtrl alone sees LED registers.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    if (bus.SwitchCtrl) begin
      case (offset)
        OFF_LED:   rdata = led_reg;
        OFF_BLINK: rdata = blink_mask;
        OFF_SW:    rdata = stable;
        OFF_CHG:   rdata = {15'b0, sw_changed};
        default:   rdata = '0;
      endcase
    end else if (bus.LEDCtrl) begin
      case (offset)
        OFF_LED:   rdata = led_reg;
        OFF_BLINK: rdata = blink_mask;
        default:   rdata = '0;
      endcase
    end
  end

  assign bus.io_rdata = rdata;

endmodule

// File: doc/led_switch_io.md
# led_switch_io

Memory-mapped LED/switch peripheral: the device-side responder to the CPU's IO chip selects (`LEDCtrl`, `SwitchCtrl`), address and `write_data`, returning 16-bit `io_rdata`. It latches LED writes with per-bit blink support and synchronises and debounces the board switches. It also keeps a sticky switch-change flag that is cleared on read. It sits between the CPU's memory/IO routing logic and the board LED/switch pins.

## Interface
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles needed before a switch vector is accepted (≥2).
- `BLINK_CYCLES`, 5000000: clocks per blink half-period (≥2).
- `clock` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high; all state cleared on a rising edge with `reset`=1.
- `LEDCtrl` in 1: LED chip select; a write strobe for the current cycle.
- `SwitchCtrl` in 1: switch chip select; a read strobe for the current cycle.
- `addr` in 32: CPU address; only `addr[7:0]` is decoded.
- `write_data` in 32: CPU store data; only bits [15:0] are used.
- `switch_in` in 16: raw asynchronous board switches.
- `io_rdata` out 16: read data to the CPU.
- `led` out 16: board LEDs.

## Operation
- Register map by `addr[7:0]`:
  - 0x60: LED data, R/W via `LEDCtrl`.
  - 0x64: blink mask, R/W via `LEDCtrl`.
  - 0x70: debounced switches, read-only.
  - 0x74: `{15'b0, sw_changed}`, read-only, clear-on-read.
- LED writes: at a rising edge with `LEDCtrl`=1, offset 0x60 loads `led_reg`, or offset 0x64 loads `blink_mask`, from `write_data[15:0]`. Other offsets are ignored.
- `io_rdata` is combinational:
  - When `SwitchCtrl`=1: the register selected by the offset; an unmapped offset reads 0.
  - When `LEDCtrl`=1 and `SwitchCtrl`=0: `led_reg` or `blink_mask` at 0x60/0x64; an unmapped offset reads 0.
  - Otherwise: 16'h0000.
- Blink:
  - `blink_cnt` counts 0..`BLINK_CYCLES`-1 and wraps; `phase` toggles on each wrap.
  - `led = led_reg & ~(blink_mask & {16{phase}})`.
- Switch path:
  - Two-flop synchroniser `sync1` → `sync2`.
  - Then a debounce FSM over the whole vector, with registers `cand`, `cnt`, `stable`.
- Debounce, evaluated every edge in this priority order:
  - If `sync2` ≠ `cand`: `cand` ← `sync2`, `cnt` ← 0.
  - Else if `cnt` = `DEBOUNCE_CYCLES`-1:
    - If `cand` ≠ `stable`: `stable` ← `cand`, `sw_changed` ← 1.
    - `cnt` holds (saturates).
  - Else: `cnt` ← `cnt`+1.
- A bounce shorter than `DEBOUNCE_CYCLES` stable cycles never reaches `stable`.
- Clear-on-read: a rising edge with `SwitchCtrl`=1 and offset 0x74 clears `sw_changed`. If a commit occurs on the same edge, set wins and `sw_changed` stays 1.
- Simultaneous `LEDCtrl` and `SwitchCtrl`: the LED write still occurs; `io_rdata` follows the `SwitchCtrl` rule.

## Timing
- Reset values: `led_reg`, `blink_mask`, `blink_cnt`, `phase`, `sync1`, `sync2`, `cand`, `cnt`, `stable` and `sw_changed` are all 0.
- Outputs after reset: `led`=0, and `io_rdata`=0 with no chip select.
- LED write latency: `led` reflects a write from the edge that samples `LEDCtrl` onward (1 cycle).
- Read latency: 0 cycles. Data is valid in the same cycle as `SwitchCtrl`, so the CPU register write captures it at that cycle's edge.
- Switch latency:
  - A change on `switch_in` before edge E0, held steady, reaches `stable` at edge E0+`DEBOUNCE_CYCLES`+2.
  - It is visible at 0x70 in the following cycle.
  - `sw_changed` sets on that same edge.
- Blink: `phase` first toggles at edge `BLINK_CYCLES` after reset release and then every `BLINK_CYCLES` edges (period 2×`BLINK_CYCLES`).
- Reset mid-operation: an in-progress debounce is discarded, and `stable` returns to 0 with no `sw_changed`. A held nonzero `switch_in` re-qualifies with full latency.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `BLINK_CYCLES`=8.
- Reset: hold `reset` 2 cycles, with `switch_in`=16'hFFFF → `led`=0, `io_rdata`=0; reads of 0x70 and 0x74 return 0 until qualification.
- LED write/readback:
  - Write 0x60 ← 32'h1234_A5A5 → `led`=16'hA5A5 the next cycle.
  - A read of 0x60 under `LEDCtrl` returns 16'hA5A5.
  - A write to 0x68 changes nothing.
- Blink:
  - Set `led_reg`=16'h00FF and `blink_mask`=16'h000F.
  - `led` alternates 16'h00FF / 16'h00F0 every 8 cycles.
- Debounce accept:
  - `switch_in` 0 → 16'h0055, held.
  - 0x70 reads 16'h0055 exactly from the cycle after edge E0+6.
  - 0x74 reads 1, then reads 0 after one clear-on-read edge.
- Bounce reject: toggle `switch_in` between 16'h0001 and 0 every 3 cycles for 30 cycles, then return it to 0 → `stable` stays 0 and `sw_changed` stays 0.
- Collision: a clear-on-read of 0x74 on the same edge as a new commit → `sw_changed` remains 1. Assert `reset` mid-qualification → `stable`=0.
